// File: rtl/bsg_mesh_router_pkg.sv
// ============================================================================
// bsg_mesh_router_pkg
//   Shared types for the mesh router allocator and arbiters.
//   Rev 1.0
// ============================================================================
`default_nettype none

package bsg_mesh_router_pkg;

    typedef enum logic {
        e_alloc_idle = 1'b0,
        e_alloc_busy = 1'b1
    } alloc_state_e;

endpackage

`default_nettype wire

// File: rtl/bsg_mesh_router_rr_pick.sv
// ============================================================================
// bsg_mesh_router_rr_pick
//   Combinational rotate-priority pick: first set bit after last_i, wrapping.
//   Rev 1.0
// ============================================================================
`default_nettype none

module bsg_mesh_router_rr_pick
    import bsg_mesh_router_pkg::*;
#(
    parameter int dirs_p    = 5,
    parameter int lg_dirs_p = (dirs_p > 1) ? $clog2(dirs_p) : 1
) (
    input  logic [lg_dirs_p-1:0] last_i,
    input  logic [dirs_p-1:0]    e_i,
    output logic [lg_dirs_p-1:0] sel_o,
    output logic                 v_o,
    output logic [dirs_p-1:0]    onehot_o
);

    logic w_found;

    // Scan last_i+1 .. last_i+dirs_p so the most recent winner is tried last.
    always_comb begin
        w_found = 1'b0;
        sel_o   = '0;
        for (int k = 1; k <= dirs_p; k++) begin
            if (!w_found && e_i[(int'(last_i) + k) % dirs_p]) begin
                w_found = 1'b1;
                sel_o   = lg_dirs_p'((int'(last_i) + k) % dirs_p);
            end
        end
    end

    assign v_o      = w_found;
    assign onehot_o = {{(dirs_p-1){1'b0}}, w_found} << sel_o;

endmodule

`default_nettype wire

// File: rtl/bsg_mesh_router_output_alloc_rr.sv
// ============================================================================
// bsg_mesh_router_output_alloc_rr
//   Wormhole round-robin allocator for one router output port.
//   Rev 1.0
// ============================================================================
`default_nettype none

module bsg_mesh_router_output_alloc_rr
    import bsg_mesh_router_pkg::*;
#(
    parameter int                dirs_p      = 5,
    parameter int                len_width_p = 4,
    parameter logic [dirs_p-1:0] in_mask_p   = '0
) (
    input  logic                          clk_i,
    input  logic                          reset_n_i,
    input  logic [dirs_p-1:0]             v_i,
    input  logic [dirs_p-1:0]             req_i,
    input  logic [dirs_p*len_width_p-1:0] len_i,
    input  logic                          ready_i,
    output logic                          v_o,
    output logic [dirs_p-1:0]             grant_o,
    output logic [dirs_p-1:0]             yumi_o,
    output logic                          busy_o
);

    localparam int                     c_LG_DIRS    = (dirs_p > 1) ? $clog2(dirs_p) : 1;
    localparam logic [c_LG_DIRS-1:0]   c_LAST_RESET = c_LG_DIRS'(dirs_p - 1);
    localparam logic [len_width_p-1:0] c_CNT_ONE    = len_width_p'(1);

    alloc_state_e           state_q, state_d;
    logic [c_LG_DIRS-1:0]   owner_q, owner_d;
    logic [c_LG_DIRS-1:0]   last_q,  last_d;
    logic [len_width_p-1:0] cnt_q,   cnt_d;

    logic [dirs_p-1:0]      w_elig;
    logic [c_LG_DIRS-1:0]   w_sel;
    logic                   w_any;
    logic [dirs_p-1:0]      w_sel_oh;
    logic [dirs_p-1:0]      w_owner_oh;
    logic [len_width_p-1:0] w_sel_len;
    logic                   w_v;
    logic                   w_owner_hs;
    logic [dirs_p-1:0]      w_grant;
    logic [dirs_p-1:0]      w_yumi;

    assign w_elig     = req_i & ~in_mask_p;
    assign w_sel_len  = len_i[int'(w_sel)*len_width_p +: len_width_p];
    assign w_owner_oh = {{(dirs_p-1){1'b0}}, 1'b1} << owner_q;
    assign w_owner_hs = v_i[owner_q] & ready_i;

    bsg_mesh_router_rr_pick #(
        .dirs_p    (dirs_p),
        .lg_dirs_p (c_LG_DIRS)
    ) u_pick (
        .last_i   (last_q),
        .e_i      (w_elig),
        .sel_o    (w_sel),
        .v_o      (w_any),
        .onehot_o (w_sel_oh)
    );

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        w_v     = 1'b0;
        w_grant = '0;
        w_yumi  = '0;
        case (state_q)
            e_alloc_idle: begin
                w_v     = w_any;
                w_grant = w_sel_oh;
                w_yumi  = w_sel_oh & {dirs_p{ready_i}};
                // A zero-length packet is just the header; stay free to re-arbitrate.
                if (w_any && ready_i) begin
                    last_d = w_sel;
                    if (w_sel_len != '0) begin
                        state_d = e_alloc_busy;
                        owner_d = w_sel;
                        cnt_d   = w_sel_len;
                    end
                end
            end
            e_alloc_busy: begin
                w_v     = v_i[owner_q];
                w_grant = w_owner_oh;
                w_yumi  = w_owner_oh & {dirs_p{w_owner_hs}};
                if (w_owner_hs) begin
                    cnt_d = cnt_q - c_CNT_ONE;
                    if (cnt_q == c_CNT_ONE) begin
                        state_d = e_alloc_idle;
                    end
                end
            end
            default: state_d = e_alloc_idle;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= e_alloc_idle;
            owner_q <= '0;
            cnt_q   <= '0;
            last_q  <= c_LAST_RESET;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    assign v_o     = w_v & reset_n_i;
    assign grant_o = w_grant & {dirs_p{reset_n_i}};
    assign yumi_o  = w_yumi & {dirs_p{reset_n_i}};
    assign busy_o  = (state_q == e_alloc_busy) & reset_n_i;

`ifndef SYNTHESIS
    logic [dirs_p-1:0]             v_prev_q;
    logic [dirs_p-1:0]             yumi_prev_q;
    logic [dirs_p*len_width_p-1:0] len_prev_q;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            v_prev_q    <= '0;
            yumi_prev_q <= '0;
            len_prev_q  <= '0;
        end else begin
            v_prev_q    <= v_i;
            yumi_prev_q <= yumi_o;
            len_prev_q  <= len_i;
        end
    end

    // A waiting head flit must not change its length field until dequeued.
    always_ff @(posedge clk_i) begin
        if (reset_n_i) begin
            assert ($onehot0(grant_o));
            assert ((yumi_o & ~grant_o) == '0);
            if (busy_o) assert (grant_o == w_owner_oh);
            for (int i = 0; i < dirs_p; i++) begin
                if (v_prev_q[i] && !yumi_prev_q[i] && v_i[i])
                    assert (len_i[i*len_width_p +: len_width_p] ==
                            len_prev_q[i*len_width_p +: len_width_p]);
            end
        end
    end
`endif

endmodule

`default_nettype wire
